// File: rtl/ay3891x_seq.sv
// Command sequencer for the ay3891x PSG write bus: FIFO of 16-bit commands expanded into address/data write pairs or tick-counted waits.
// Optional shadow register copy enabled with `define AY3891X_SEQ_SHADOW_EN.
module ay3891x_seq #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WAIT_W     = 15
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef AY3891X_SEQ_SHADOW_EN
  input  logic [3:0]            shadow_addr,
  output logic [7:0]            shadow_data,
`endif
  input  logic                  cmd_valid,
  input  logic [15:0]           cmd_data,
  output logic                  cmd_ready,
  input  logic                  flush,
  input  logic                  tick,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  psg_a0,
  output logic                  psg_wr_tick,
  output logic [7:0]            psg_wdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT} state_t;

  state_t                  state, state_next;
  logic [WAIT_W-1:0]       wait_cnt, wait_cnt_next;
  logic [11:0]             cur_cmd;
  logic                    push, pop;
  logic [15:0]             mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [15:0]             head;
  logic                    a0_next, wr_next;
  logic [7:0]              wdata_next;

  assign cmd_ready = (fifo_count != FULL_COUNT);
  assign push      = cmd_valid && cmd_ready && !flush;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= cmd_data;
  end

  // flush empties the queue by snapping the read pointer onto the write pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      rd_ptr     <= wr_ptr;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (push && !pop)
        fifo_count <= fifo_count + (DEPTH_LOG2+1)'(1);
      else if (pop && !push)
        fifo_count <= fifo_count - (DEPTH_LOG2+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      cur_cmd  <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (pop)
        cur_cmd <= head[11:0];
    end
  end

  // ADDR always proceeds to DATA so a flush never leaves a dangling address
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && (fifo_count != '0)) begin
          pop = 1'b1;
          if (!head[15]) begin
            state_next = ADDR;
          end else if (|head[WAIT_W-1:0]) begin
            state_next    = WAIT;
            wait_cnt_next = head[WAIT_W-1:0];
          end
        end
      end
      ADDR: state_next = DATA;
      DATA: state_next = IDLE;
      WAIT: begin
        if (flush) begin
          state_next = IDLE;
        end else if (tick) begin
          wait_cnt_next = wait_cnt - WAIT_W'(1);
          if (wait_cnt == WAIT_W'(1))
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    a0_next    = 1'b0;
    wr_next    = 1'b0;
    wdata_next = psg_wdata;
    case (state)
      ADDR: begin
        wr_next    = 1'b1;
        wdata_next = {4'h0, cur_cmd[11:8]};
      end
      DATA: begin
        a0_next    = 1'b1;
        wr_next    = 1'b1;
        wdata_next = cur_cmd[7:0];
      end
      default: ;
    endcase
  end

  // PSG bus outputs are registered, trailing the FSM state by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      psg_a0      <= 1'b0;
      psg_wr_tick <= 1'b0;
      psg_wdata   <= 8'h00;
    end else begin
      psg_a0      <= a0_next;
      psg_wr_tick <= wr_next;
      psg_wdata   <= wdata_next;
    end
  end

`ifdef AY3891X_SEQ_SHADOW_EN
  logic [7:0] shadow_mem [0:15];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++)
        shadow_mem[i] <= 8'h00;
    end else if (state == DATA) begin
      shadow_mem[cur_cmd[11:8]] <= cur_cmd[7:0];
    end
  end

  assign shadow_data = shadow_mem[shadow_addr];
`endif

endmodule
